// File: rtl/hangman_game_ctrl_pkg.sv
// Shared constants, state encoding and ASCII helpers for the word-guess controller.
package hangman_game_ctrl_pkg;

  localparam logic [6:0] MASK_CHAR_DFLT = 7'h2D;
  localparam logic [6:0] ASCII_LC_A     = 7'h61;
  localparam logic [6:0] ASCII_LC_Z     = 7'h7A;
  localparam logic [6:0] ASCII_UC_A     = 7'h41;
  localparam logic [6:0] ASCII_UC_Z     = 7'h5A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PLAY,
    S_CHECK,
    S_WIN,
    S_LOSE
  } state_e;

  function automatic logic [6:0] to_lower(input logic [6:0] c);
    if (c >= ASCII_UC_A && c <= ASCII_UC_Z) return c + 7'h20;
    return c;
  endfunction

  function automatic logic is_letter(input logic [6:0] c);
    return (c >= ASCII_LC_A) && (c <= ASCII_LC_Z);
  endfunction

  function automatic logic [4:0] letter_idx(input logic [6:0] c);
    return 5'(c - ASCII_LC_A);
  endfunction

endpackage

// File: rtl/hangman_game_ctrl_letter_match_vec.sv
// Combinational compare of one letter against every stored word position.
module letter_match_vec #(
  parameter int unsigned WORD_LEN = 7
) (
  input  logic [6:0]            letter_i,
  input  logic [7*WORD_LEN-1:0] word_i,
  output logic [WORD_LEN-1:0]   match_o
);

  always_comb begin
    match_o = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      match_o[i] = (word_i[7*i +: 7] == letter_i);
    end
  end

endmodule

// File: rtl/hangman_game_ctrl.sv
// Round sequencer for the word-guess game: word load, guess checking,
// reveal mask, guessed-letter set, miss counter and win/lose levels.
module hangman_game_ctrl
  import hangman_game_ctrl_pkg::*;
#(
  parameter int unsigned WORD_LEN   = 7,
  parameter int unsigned MAX_MISSES = 6,
  parameter logic [6:0]  MASK_CHAR  = MASK_CHAR_DFLT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7*WORD_LEN-1:0] word,
  input  logic                  guess_valid,
  input  logic [6:0]            guess_ascii,
  output logic                  guess_ready,
  output logic [7*WORD_LEN-1:0] disp_word,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [2:0]            miss_count,
  output logic                  hit,
  output logic                  miss,
  output logic                  repeat_g,
  output logic                  invalid,
  output logic                  win,
  output logic                  lose,
  output logic                  busy
);

  state_e                state_q;
  logic [7*WORD_LEN-1:0] word_q, word_norm;
  logic [WORD_LEN-1:0]   revealed_q, revealed_d, pre_rev, match;
  logic [25:0]           guessed_q;
  logic [2:0]            miss_q, miss_d;
  logic [6:0]            guess_q;
  logic [4:0]            gidx;
  logic                  hit_q, miss_p_q, repeat_q, invalid_q, win_q, lose_q;

  always_comb begin
    word_norm = '0;
    pre_rev   = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      word_norm[7*i +: 7] = to_lower(word[7*i +: 7]);
      pre_rev[i]          = ~is_letter(to_lower(word[7*i +: 7]));
    end
  end

  letter_match_vec #(.WORD_LEN(WORD_LEN)) u_match (
    .letter_i (guess_q),
    .word_i   (word_q),
    .match_o  (match)
  );

  assign gidx       = letter_idx(guess_q);
  assign revealed_d = revealed_q | match;
  assign miss_d     = (miss_q < 3'(MAX_MISSES)) ? miss_q + 3'd1 : miss_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      word_q     <= '0;
      revealed_q <= '0;
      guessed_q  <= '0;
      miss_q     <= '0;
      guess_q    <= '0;
      hit_q      <= 1'b0;
      miss_p_q   <= 1'b0;
      repeat_q   <= 1'b0;
      invalid_q  <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      hit_q     <= 1'b0;
      miss_p_q  <= 1'b0;
      repeat_q  <= 1'b0;
      invalid_q <= 1'b0;
      // start overrides everything, including an in-flight CHECK, which is dropped silently
      if (start) begin
        state_q    <= S_LOAD;
        word_q     <= word_norm;
        revealed_q <= pre_rev;
        guessed_q  <= '0;
        miss_q     <= '0;
        win_q      <= 1'b0;
        lose_q     <= 1'b0;
      end else begin
        case (state_q)
          S_LOAD: begin
            if (&revealed_q) begin
              state_q <= S_WIN;
              win_q   <= 1'b1;
            end else begin
              state_q <= S_PLAY;
            end
          end
          S_PLAY: begin
            if (guess_valid) begin
              guess_q <= to_lower(guess_ascii);
              state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            state_q <= S_PLAY;
            if (!is_letter(guess_q)) begin
              invalid_q <= 1'b1;
            end else if (guessed_q[gidx]) begin
              repeat_q <= 1'b1;
            end else if (|match) begin
              hit_q           <= 1'b1;
              revealed_q      <= revealed_d;
              guessed_q[gidx] <= 1'b1;
              if (&revealed_d) begin
                state_q <= S_WIN;
                win_q   <= 1'b1;
              end
            end else begin
              miss_p_q        <= 1'b1;
              miss_q          <= miss_d;
              guessed_q[gidx] <= 1'b1;
              if (miss_d == 3'(MAX_MISSES)) begin
                state_q <= S_LOSE;
                lose_q  <= 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    disp_word = '0;
    for (int unsigned i = 0; i < WORD_LEN; i++) begin
      if (state_q == S_LOSE || (state_q != S_IDLE && revealed_q[i]))
        disp_word[7*i +: 7] = word_q[7*i +: 7];
      else
        disp_word[7*i +: 7] = MASK_CHAR;
    end
  end

  assign guess_ready = (state_q == S_PLAY) & ~start;
  assign busy        = (state_q == S_LOAD) | (state_q == S_CHECK);
  assign revealed    = revealed_q;
  assign miss_count  = miss_q;
  assign hit         = hit_q;
  assign miss        = miss_p_q;
  assign repeat_g    = repeat_q;
  assign invalid     = invalid_q;
  assign win         = win_q;
  assign lose        = lose_q;

endmodule

// File: tb/tb_hangman_game_ctrl.sv
// Scoreboard bench for hangman_game_ctrl: a small game model predicts each result pulse.
module tb_hangman_game_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [48:0] word;
  logic        guess_valid;
  logic [6:0]  guess_ascii;
  logic        guess_ready;
  logic [48:0] disp_word;
  logic [6:0]  revealed;
  logic [2:0]  miss_count;
  logic        hit, miss, repeat_g, invalid, win, lose, busy;

  hangman_game_ctrl #(.WORD_LEN(7), .MAX_MISSES(6), .MASK_CHAR(7'h2D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word(word),
    .guess_valid(guess_valid), .guess_ascii(guess_ascii), .guess_ready(guess_ready),
    .disp_word(disp_word), .revealed(revealed), .miss_count(miss_count),
    .hit(hit), .miss(miss), .repeat_g(repeat_g), .invalid(invalid),
    .win(win), .lose(lose), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] kind;
    logic [2:0] misses;
    logic [6:0] rev;
    int         cyc;
  } sb_t;

  sb_t sb[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;

  byte        m_word[7];
  bit [25:0]  m_guessed;
  logic [6:0] m_rev;
  int         m_miss;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [48:0] pack(input string s);
    logic [48:0] w;
    byte c;
    w = '0;
    for (int i = 0; i < 7; i++) begin
      c = (i < s.len()) ? s[i] : " ";
      w[7*i +: 7] = c[6:0];
    end
    return w;
  endfunction

  function automatic byte lc(input byte c);
    return (c >= "A" && c <= "Z") ? byte'(c + 8'd32) : c;
  endfunction

  function automatic bit letter(input byte c);
    return (c >= "a" && c <= "z");
  endfunction

  function automatic void model_start(input string s);
    byte c;
    m_guessed = '0;
    m_miss    = 0;
    for (int i = 0; i < 7; i++) begin
      c = (i < s.len()) ? lc(s[i]) : " ";
      m_word[i] = c;
      m_rev[i]  = !letter(c);
    end
  endfunction

  // kind = {hit, miss, repeat_g, invalid}
  function automatic logic [3:0] model_guess(input byte ch);
    byte l;
    bit  any;
    l = lc(ch);
    if (!letter(l)) return 4'b0001;
    if (m_guessed[l - "a"]) return 4'b0010;
    m_guessed[l - "a"] = 1'b1;
    any = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (m_word[i] == l) begin
        m_rev[i] = 1'b1;
        any = 1'b1;
      end
    end
    if (any) return 4'b1000;
    if (m_miss < 6) m_miss++;
    return 4'b0100;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    sb_t e;
    #1;
    if (rst_n && ({hit, miss, repeat_g, invalid} != 4'b0)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {hit, miss, repeat_g, invalid}, 4'b0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {hit, miss, repeat_g, invalid}, e.kind);
        chk("miss_count", miss_count, e.misses);
        chk("revealed", revealed, e.rev);
        chk("latency", cyc - e.cyc, 2);
      end
    end
  end

  task automatic do_start(input string s);
    @(negedge clk);
    start = 1'b1;
    word  = pack(s);
    model_start(s);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_guess(input byte ch);
    sb_t e;
    int  n;
    n = 0;
    while (!guess_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!guess_ready) begin
      chk("ready_timeout", 0, 1);
      return;
    end
    guess_valid = 1'b1;
    guess_ascii = ch[6:0];
    e.kind   = model_guess(ch);
    e.misses = 3'(m_miss);
    e.rev    = m_rev;
    e.cyc    = cyc;
    sb.push_back(e);
    @(negedge clk);
    guess_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 6) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("pulse_timeout", 0, 1);
      sb.delete();
    end
  endtask

  initial begin
    string seq;
    rst_n = 1'b0; start = 1'b0; word = '0; guess_valid = 1'b0; guess_ascii = '0;
    #23;
    chk("rst_disp", disp_word, pack("-------"));
    chk("rst_revealed", revealed, 0);
    chk("rst_misses", miss_count, 0);
    chk("rst_flags", {guess_ready, busy, win, lose, hit, miss, repeat_g, invalid}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_start("hangman");
    chk("load_busy", {busy, guess_ready}, 2'b10);
    @(negedge clk);
    chk("play_ready", guess_ready, 1);
    chk("play_disp", disp_word, pack("-------"));
    chk("play_revealed", revealed, 0);

    do_guess("A");
    chk("a_revealed", revealed, 7'b0100010);
    chk("a_disp", disp_word, pack("-a---a-"));
    do_guess("a");
    do_guess("7");
    chk("after_inv_misses", miss_count, 0);
    chk("after_inv_revealed", revealed, 7'b0100010);

    seq = "bcdefi";
    for (int i = 0; i < seq.len(); i++) begin
      chk("not_lost_yet", lose, 0);
      do_guess(seq[i]);
    end
    chk("lose_level", {lose, win, guess_ready}, 3'b100);
    chk("lose_misses", miss_count, 6);
    chk("lose_disp", disp_word, pack("hangman"));
    chk("lose_revealed", revealed, 7'b0100010);
    guess_valid = 1'b1; guess_ascii = 7'h68;
    repeat (4) @(negedge clk);
    guess_valid = 1'b0;
    chk("lose_hold", {lose, miss_count}, {1'b1, 3'd6});

    do_start("HangMan");
    chk("restart_clear", {lose, win, miss_count}, 0);
    seq = "hangm";
    for (int i = 0; i < seq.len(); i++) begin
      chk("not_won_yet", win, 0);
      do_guess(seq[i]);
    end
    chk("win_level", {win, lose, guess_ready}, 3'b100);
    chk("win_revealed", revealed, 7'h7F);
    chk("win_misses", miss_count, 0);
    chk("win_disp", disp_word, pack("hangman"));

    // start while a guess sits in CHECK
    do_start("hangman");
    @(negedge clk);
    do_guess("h");
    guess_valid = 1'b1; guess_ascii = 7'h78;
    @(negedge clk);
    chk("in_check", busy, 1);
    guess_valid = 1'b0;
    start = 1'b1; word = pack("hangman");
    model_start("hangman");
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_ready", {guess_ready, busy}, 2'b10);
    chk("abort_revealed", revealed, 0);
    do_guess("h");

    // start coinciding with guess_valid
    @(negedge clk);
    start = 1'b1; word = pack("hangman"); guess_valid = 1'b1; guess_ascii = 7'h61;
    model_start("hangman");
    @(negedge clk);
    start = 1'b0; guess_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("coinc_ready", {guess_ready, busy}, 2'b10);
    chk("coinc_revealed", revealed, 0);
    do_guess("h");

    do_start("ab c");
    @(negedge clk);
    chk("space_revealed", revealed, 7'b1110100);
    chk("space_disp", disp_word, pack("-- -"));
    do_guess("b");
    do_guess("C");
    do_guess("a");
    chk("space_win", win, 1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=%0d", cyc, 0);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hangman_game_ctrl.md
Name: hangman_game_ctrl

Overview:
- Sequencing controller for one seven-letter word-guess game round.
- Loads a secret word, accepts one guess per handshake and compares it against every letter position.
- Maintains the revealed-letter mask, the set of already-guessed letters and the miss counter; declares win or lose.
- Feeds the display/text path with masked ASCII characters, with the dash character in unrevealed positions.

Parameters:
- WORD_LEN, 7: number of letter positions.
- MAX_MISSES, 6: wrong guesses that end the round in LOSE.
- MASK_CHAR, 7'h2D: ASCII shown for an unrevealed position ('-').

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; loads word and begins a round.
- word  in  7*WORD_LEN  secret word; position 0 in bits [6:0]; sampled only when start=1.
- guess_valid  in  1  guess offered.
- guess_ascii  in  7  guessed character.
- guess_ready  out  1  controller can accept a guess; equals (state==PLAY) & ~start.
- disp_word  out  7*WORD_LEN  per position: the stored letter if revealed, else MASK_CHAR.
- revealed  out  WORD_LEN  per-position reveal mask.
- miss_count  out  3  wrong guesses so far.
- hit, miss, repeat_g, invalid  out  1 each  one-cycle result pulses.
- win, lose  out  1  level; held until the next start or reset.
- busy  out  1  state is LOAD or CHECK.

Behaviour:
- Reset (async assert, sync-release usage) drives every output and register to 0, except disp_word, which shows MASK_CHAR in all positions. State = IDLE.
- Normalisation:
  - Uppercase 'A'..'Z' maps to lowercase.
  - A character is a letter iff it is 'a'..'z' after normalisation.
  - Word characters are normalised before storage.
- FSM states: IDLE, LOAD, PLAY, CHECK, WIN, LOSE.
- start, any state including CHECK: next state = LOAD.
  - Store the normalised word; clear the guessed set (26 bits), miss_count, win and lose.
  - revealed[i] = 1 for each non-letter word position. Spaces and punctuation are pre-revealed.
  - start has priority over a same-cycle guess_valid; guess_ready is already low, so no guess is accepted.
- LOAD, 1 cycle: if all revealed bits are 1, go to WIN; else go to PLAY.
- PLAY: a guess is accepted on guess_valid & guess_ready. On acceptance, latch the normalised guess and go to CHECK.
- CHECK, 1 cycle. Outcome is registered at the end of the cycle and is visible one cycle after CHECK, i.e. 2 cycles after the acceptance edge. Priority order:
  1. Not a letter: pulse invalid. No counter or mask change. Go to PLAY.
  2. Letter already in the guessed set: pulse repeat_g. No miss is counted. Go to PLAY.
  3. Matches at least one position: set revealed[i] for every matching position (duplicate letters are revealed together); pulse hit; add the letter to the guessed set. Go to WIN if the mask becomes all ones, else PLAY.
  4. No match: increment miss_count; pulse miss; add the letter to the guessed set. Go to LOSE if miss_count reaches MAX_MISSES, else PLAY.
- WIN / LOSE: the matching level is asserted. guess_ready = 0. In LOSE, disp_word shows the full word (all positions revealed for display only; the revealed output is unchanged). Exit only via start or reset.
- IDLE: guess_ready = 0; disp_word shows all MASK_CHAR.
- miss_count saturates at MAX_MISSES and never wraps.
- Result pulses are mutually exclusive, and exactly one fires per accepted guess.
- Reset mid-CHECK discards the guess with no pulse.

Decomposition:
- Shared package holds:
  - ASCII constants: MASK_CHAR, 'a', 'z', 'A', 'Z'.
  - State enum encoding.
  - The to_lower / is_letter functions.
- One sub-module, letter_match_vec: combinational compare of one 7-bit letter against WORD_LEN stored letters, returning a WORD_LEN-bit match vector. The FSM, mask, guessed set and counters stay in the top module.

Test Plan:
- Reset, then start with word "hangman" -> LOAD then PLAY. disp_word = "-------", revealed = 0, guess_ready = 1 two cycles after start.
- Guess 'A' -> hit 2 cycles after acceptance. revealed = 7'b0100010 (positions 1 and 5). disp_word = "-a---a-". miss_count = 0.
- Guess 'a' again, then '7' -> repeat_g pulse, then invalid pulse. miss_count stays 0 and the mask is unchanged.
- Guesses 'b','c','d','e','f','i' -> six miss pulses. miss_count = 6, lose = 1, disp_word = "hangman", guess_ready = 0. A further guess_valid is ignored.
- Restart, then guess h, a, n, g, m -> win = 1 after 'm'. revealed = 7'h7F. miss_count = 0.
- start asserted during CHECK, and start coinciding with guess_valid -> the guess is discarded, no result pulse. State goes LOAD -> PLAY with a cleared guessed set. Also: word "ab c" (padded with spaces) enters PLAY with space positions pre-revealed.
